// File: rtl/crypt_pkg.sv
// Shared widths, packet layout, mask function and LFSR taps for the function-1 cipher pair.
// encrypt_function_1 and decrypt_function_1 both import this package.
package crypt_pkg;

  localparam int unsigned PT_W  = 60;
  localparam int unsigned KEY_W = 11;
  localparam int unsigned CT_W  = 61;
  localparam int unsigned TAG_W = 6;
  localparam int unsigned PKT_W = 78;

  // Fibonacci taps: feedback bit = s[LFSR_TAP_HI] ^ s[LFSR_TAP_LO]
  localparam int unsigned LFSR_TAP_HI = 10;
  localparam int unsigned LFSR_TAP_LO = 8;

  typedef struct packed {
    logic [PT_W-1:0]  x;
    logic [KEY_W-1:0] key;
  } s1_t;

  typedef struct packed {
    logic [CT_W-1:0]  y;
    logic [KEY_W-1:0] key;
    logic [TAG_W-1:0] func_id;
  } pkt_t;

  // 60-bit mask built from the 11-bit key, low segment first.
  function automatic logic [PT_W-1:0] mask_f1(input logic [KEY_W-1:0] r);
    return {r[4:0], ~r, r, ~r, ~r, r};
  endfunction

  function automatic logic [KEY_W-1:0] lfsr_step(input logic [KEY_W-1:0] s);
    return {s[KEY_W-2:0], s[LFSR_TAP_HI] ^ s[LFSR_TAP_LO]};
  endfunction

endpackage

// File: rtl/lfsr11.sv
// 11-bit maximal-length Fibonacci LFSR with synchronous reset and optional load.
// Priority: Rst > load > adv; a zero state or zero load value falls back to SEED.
module lfsr11
  import crypt_pkg::*;
#(
  parameter logic [KEY_W-1:0] SEED = 11'h001
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             adv,
  input  logic             load,
  input  logic [KEY_W-1:0] load_val,
  output logic [KEY_W-1:0] state
);

  logic [KEY_W-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = (load_val == '0) ? SEED : load_val;
    end else if (state_q == '0) begin
      // All-zero is a lock-up state; recover regardless of adv.
      state_d = SEED;
    end else if (adv) begin
      state_d = lfsr_step(state_q);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/encrypt_function_1.sv
// Two-stage valid/ready encryption pipeline: y = x + mask_f1(key), packet {y, key, FUNC_ID}.
// Optional ENC1_SEED_LOAD_EN adds seed_load/seed_value for reloading the key LFSR.
module encrypt_function_1
  import crypt_pkg::*;
#(
  parameter logic [KEY_W-1:0] SEED    = 11'h001,
  parameter logic [TAG_W-1:0] FUNC_ID = 6'd1
) (
  input  logic             Clk,
  input  logic             Rst,
`ifdef ENC1_SEED_LOAD_EN
  input  logic             seed_load,
  input  logic [KEY_W-1:0] seed_value,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PT_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PKT_W-1:0] out_data
);

  logic             s1_valid_q, s1_valid_d;
  s1_t              s1_q, s1_d;
  logic             out_valid_q, out_valid_d;
  pkt_t             pkt_q, pkt_d;
  logic             s1_adv, s2_adv, accept;
  logic [KEY_W-1:0] key;
  logic             lfsr_load;
  logic [KEY_W-1:0] lfsr_load_val;
  logic [CT_W-1:0]  y;

`ifdef ENC1_SEED_LOAD_EN
  assign lfsr_load     = seed_load;
  assign lfsr_load_val = seed_value;
`else
  assign lfsr_load     = 1'b0;
  assign lfsr_load_val = SEED;
`endif

  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;
  assign accept   = in_valid && s1_adv;

  // Key for an accepted beat is the pre-advance (and pre-load) state.
  lfsr11 #(
    .SEED(SEED)
  ) u_lfsr (
    .Clk     (Clk),
    .Rst     (Rst),
    .adv     (accept),
    .load    (lfsr_load),
    .load_val(lfsr_load_val),
    .state   (key)
  );

  // 61-bit sum keeps the carry so the decoder can subtract exactly.
  assign y = {1'b0, s1_q.x} + {1'b0, mask_f1(s1_q.key)};

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_d        = s1_q;
    out_valid_d = out_valid_q;
    pkt_d       = pkt_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (accept) begin
        s1_d.x   = in_data;
        s1_d.key = key;
      end
    end
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        pkt_d.y       = y;
        pkt_d.key     = s1_q.key;
        pkt_d.func_id = FUNC_ID;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      pkt_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_q        <= s1_d;
      out_valid_q <= out_valid_d;
      pkt_q       <= pkt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = pkt_q;

endmodule

// File: tb/tb_encrypt_function_1.sv
// Directed + random bench for encrypt_function_1 with a queue scoreboard and independent model.
// Honours ENC1_SEED_LOAD_EN when the design is built with it.
module tb_encrypt_function_1;

  localparam logic [10:0] SEED = 11'h001;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        in_valid;
  logic        in_ready;
  logic [59:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [77:0] out_data;
`ifdef ENC1_SEED_LOAD_EN
  logic        seed_load;
  logic [10:0] seed_value;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int stalls = 0;

  logic [77:0] exp_q[$];
  logic [59:0] x_q[$];
  logic [10:0] lfsr_m;

  always #5 Clk = ~Clk;

  encrypt_function_1 #(
    .SEED   (SEED),
    .FUNC_ID(6'd1)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
`ifdef ENC1_SEED_LOAD_EN
    .seed_load (seed_load),
    .seed_value(seed_value),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // Mask model written bit by bit: segments 1, 2 and 4 carry the inverted key.
  function automatic logic [59:0] mask_tb(input logic [10:0] r);
    logic [59:0] b;
    for (int i = 0; i < 60; i++) begin
      int seg;
      seg  = i / 11;
      b[i] = r[i % 11] ^ ((seg == 1) || (seg == 2) || (seg == 4));
    end
    return b;
  endfunction

  function automatic logic [10:0] lfsr_tb(input logic [10:0] s);
    if (s == 11'h000) return SEED;
    return {s[9:0], s[10] ^ s[8]};
  endfunction

  function automatic logic [77:0] pkt_tb(input logic [59:0] x, input logic [10:0] r);
    logic [60:0] y;
    y = {1'b0, x} + {1'b0, mask_tb(r)};
    return {y, r, 6'd1};
  endfunction

  task automatic check(input string tag, input logic [77:0] obs, input logic [77:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: inputs change only at posedge+1, so the negedge sees what the next edge samples.
  always @(negedge Clk) begin
    logic [77:0] exp_pkt;
    logic [59:0] exp_x;
    logic [60:0] y_full;
    logic [60:0] diff;
    if (Rst) begin
      exp_q.delete();
      x_q.delete();
      lfsr_m = SEED;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", out_data, 78'h0);
          if (out_data == 78'h0) begin
            n_bad++;
            $error("FAIL unexpected_beat: observed extra packet expected none");
          end
        end else begin
          exp_pkt = exp_q.pop_front();
          exp_x   = x_q.pop_front();
          check("scoreboard_pkt", out_data, exp_pkt);
          y_full = out_data[77:17];
          diff   = y_full - {1'b0, mask_tb(out_data[16:6])};
          check("round_trip", {18'h0, diff[59:0]}, {18'h0, exp_x});
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(pkt_tb(in_data, lfsr_m));
        x_q.push_back(in_data);
        lfsr_m = lfsr_tb(lfsr_m);
      end
`ifdef ENC1_SEED_LOAD_EN
      if (seed_load) lfsr_m = (seed_value == 11'h000) ? SEED : seed_value;
`endif
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [59:0] x);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = x;
    @(negedge Clk);
    while (!in_ready && n < 200) begin
      stalls++;
      n++;
      @(posedge Clk);
      #1;
      out_ready = 1'b1;
      @(negedge Clk);
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $error("FAIL send_timeout: observed in_ready=0 expected 1 within 200 cycles");
    end
    @(posedge Clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    Rst = 1'b0;
  endtask

  task automatic drain();
    int n;
    n         = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge Clk);
      n++;
    end
    check("drain_empty", 78'(exp_q.size()), 78'h0);
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [59:0] bp[5];
    logic [77:0] held;
    logic [63:0] rnd;
    logic        acc;
    int          idx;

    Rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
`ifdef ENC1_SEED_LOAD_EN
    seed_load  = 1'b0;
    seed_value = 11'h000;
`endif

    // Reset state
    repeat (2) @(posedge Clk);
    #1;
    @(negedge Clk);
    check("reset_out_valid", 78'(out_valid), 78'h0);
    check("reset_out_data", out_data, 78'h0);
    check("reset_in_ready", 78'(in_ready), 78'h1);
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    @(negedge Clk);
    check("in_ready_after_reset", 78'(in_ready), 78'h1);
    @(posedge Clk);
    #1;

    // Zero plaintext, first key = SEED, then next key
    send(60'h0);
    check("latency_not_yet", 78'(out_valid), 78'h0);
    @(posedge Clk);
    #1;
    check("latency_valid", 78'(out_valid), 78'h1);
    check("zero_pt_pkt", out_data, {1'b0, 60'h0FFE003FFBFF001, 11'h001, 6'd1});
    send(60'h0);
    @(posedge Clk);
    #1;
    check("second_key", 78'(out_data[16:6]), 78'h002);
    drain();

    // Carry out of the 60-bit add
    do_reset();
    send(60'hFFF_FFFF_FFFF_FFFF);
    @(posedge Clk);
    #1;
    check("carry_pkt", out_data, {61'h1_0FFE003FFBFF000, 11'h001, 6'd1});
    check("carry_bit", 78'(out_data[77]), 78'h1);
    drain();

    // Backpressure: 4 cycles of out_ready=0 while streaming 5 beats
    do_reset();
    for (int i = 0; i < 5; i++) bp[i] = 60'h123_4567_89AB_0000 + 60'(i * 7919);
    out_ready = 1'b0;
    idx       = 0;
    in_valid  = 1'b1;
    in_data   = bp[0];
    held      = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge Clk);
      acc = in_ready;
      if (c == 2) begin
        check("bp_full_in_ready", 78'(in_ready), 78'h0);
        held = out_data;
      end
      if (c == 3) begin
        check("bp_hold_valid", 78'(out_valid), 78'h1);
        check("bp_hold_data", out_data, held);
      end
      @(posedge Clk);
      #1;
      if (acc) begin
        idx++;
        in_data = bp[idx];
      end
    end
    check("bp_accepts", 78'(idx), 78'h2);
    out_ready = 1'b1;
    for (int c = 0; c < 50 && idx < 5; c++) begin
      @(negedge Clk);
      acc = in_ready;
      @(posedge Clk);
      #1;
      if (acc) begin
        idx++;
        if (idx < 5) in_data = bp[idx];
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("bp_all_sent", 78'(idx), 78'h5);
    drain();

    // Random stream crossing the LFSR wrap, with random backpressure
    for (int i = 0; i < 3000; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      rnd       = {$urandom(), $urandom()};
      send(rnd[59:0]);
    end
    drain();

    // Full throughput with out_ready held high
    stalls    = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(60'(i) << 40);
    check("throughput_stalls", 78'(stalls), 78'h0);
    drain();

    // Reset while stalled discards in-flight beats
    out_ready = 1'b0;
    send(60'h1);
    send(60'h2);
    do_reset();
    @(negedge Clk);
    check("midstall_out_valid", 78'(out_valid), 78'h0);
    check("midstall_in_ready", 78'(in_ready), 78'h1);
    @(posedge Clk);
    #1;
    out_ready = 1'b1;
    send(60'h0);
    @(posedge Clk);
    #1;
    check("post_reset_pkt", out_data, {1'b0, 60'h0FFE003FFBFF001, 11'h001, 6'd1});
    drain();

`ifdef ENC1_SEED_LOAD_EN
    // Seed load concurrent with an accept: that beat keeps the old key
    do_reset();
    seed_value = 11'h5A5;
    seed_load  = 1'b1;
    send(60'hABC);
    seed_load = 1'b0;
    send(60'hDEF);
    check("seed_old_key", 78'(out_data[16:6]), 78'h001);
    @(posedge Clk);
    #1;
    check("seed_new_key", 78'(out_data[16:6]), 78'h5A5);
    drain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
